// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run/halt/step control, resource selection and hex scan display
// for the CDEC8 board shell. Optional PC breakpoint is built only when the
// CPU_DBG_BREAKPOINT_EN macro is defined.
module cpu_debug_ctrl #(
    parameter int                      AW       = 8,
    parameter int                      DW       = 8,
    parameter int                      DIGITS   = DW / 4,
    parameter int                      NUM_RES  = 4,
    parameter int                      SEL_W    = 2,
    parameter logic [NUM_RES*AW-1:0]   RES_MAP  = {8'h0e, 8'h01, 8'h08, 8'h00},
    parameter int                      SCAN_DIV = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic              endseq,
    input  logic [AW-1:0]     pc_in,
    input  logic [AW-1:0]     bp_adrs,
    input  logic              bp_en,
    input  logic [SEL_W-1:0]  ressel,
    output logic [AW-1:0]     resad,
    input  logic [DW-1:0]     resdt,
    output logic              cpu_ce,
    output logic              bp_hit,
    output logic [1:0]        mode,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig_en
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIG_ONE = 1;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state, next_state;
    logic              step_d;
    logic              step_edge;
    logic              bp_match;
    logic [DW-1:0]     disp_q;
    logic [CNT_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nib;

    function automatic logic [7:0] sseg_dec(input logic [3:0] n);
        case (n)
            4'h0: sseg_dec = 8'h3F;
            4'h1: sseg_dec = 8'h06;
            4'h2: sseg_dec = 8'h5B;
            4'h3: sseg_dec = 8'h4F;
            4'h4: sseg_dec = 8'h66;
            4'h5: sseg_dec = 8'h6D;
            4'h6: sseg_dec = 8'h7D;
            4'h7: sseg_dec = 8'h07;
            4'h8: sseg_dec = 8'h7F;
            4'h9: sseg_dec = 8'h6F;
            4'hA: sseg_dec = 8'h77;
            4'hB: sseg_dec = 8'h7C;
            4'hC: sseg_dec = 8'h39;
            4'hD: sseg_dec = 8'h5E;
            4'hE: sseg_dec = 8'h79;
            default: sseg_dec = 8'h71;
        endcase
    endfunction

    assign step_edge = step_btn & ~step_d;

`ifdef CPU_DBG_BREAKPOINT_EN
    logic bp_armed;

    assign bp_match = bp_en && (pc_in == bp_adrs) && bp_armed;

    // Arm the breakpoint only after the first RUN cycle so a resume always executes
    always_ff @(posedge clock) begin
        if (reset)
            bp_armed <= 1'b0;
        else if (state != RUN && next_state == RUN)
            bp_armed <= 1'b0;
        else if (state == RUN)
            bp_armed <= 1'b1;
    end

    // Sticky breakpoint-stop flag; endseq wins over a simultaneous match
    always_ff @(posedge clock) begin
        if (reset)
            bp_hit <= 1'b0;
        else if (state == HALT && (next_state == RUN || next_state == STEP))
            bp_hit <= 1'b0;
        else if (state == RUN && bp_match && !endseq)
            bp_hit <= 1'b1;
    end
`else
    logic unused_bp;

    assign unused_bp = ^{bp_adrs, bp_en};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // Run-control state register and step-edge detector
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= HALT;
            step_d <= 1'b0;
        end else begin
            state  <= next_state;
            step_d <= step_btn;
        end
    end

    // Next-state selection: run_sw beats step in HALT; endseq > breakpoint > run_sw low in RUN
    always_comb begin
        next_state = state;
        case (state)
            HALT: begin
                if (run_sw)
                    next_state = RUN;
                else if (step_edge)
                    next_state = STEP;
            end
            STEP: next_state = HALT;
            RUN: begin
                if (endseq)
                    next_state = DONE;
                else if (bp_match)
                    next_state = HALT;
                else if (!run_sw)
                    next_state = HALT;
            end
            default: next_state = DONE;
        endcase
    end

    // Clock enable is combinational so reset and a breakpoint match gate it in-cycle
    always_comb begin
        cpu_ce = 1'b0;
        mode   = state;
        if (!reset && (state == STEP || (state == RUN && !bp_match)))
            cpu_ce = 1'b1;
    end

    // Resource-address lookup; out-of-range selectors fall back to entry 0
    always_ff @(posedge clock) begin
        if (reset)
            resad <= RES_MAP[AW-1:0];
        else if (32'(ressel) < NUM_RES)
            resad <= RES_MAP[32'(ressel) * AW +: AW];
        else
            resad <= RES_MAP[AW-1:0];
    end

    assign nib = disp_q[{idx, 2'b00} +: 4];

    // Display capture, digit scan timing, and registered segment/enable pair
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q   <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= sseg_dec(4'h0);
            dig_en   <= DIG_ONE;
        end else begin
            disp_q <= resdt;
            seg    <= sseg_dec(nib);
            dig_en <= DIG_ONE << idx;
            if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                if (idx == IDX_W'(DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: directed run/step/breakpoint/display scenarios followed
// by randomized stimulus, all checked against a cycle-level behavioural model.
module tb_cpu_debug_ctrl;

    localparam int SD = 4;
    localparam int ND = 2;
`ifdef CPU_DBG_BREAKPOINT_EN
    localparam bit BP_BUILT = 1'b1;
`else
    localparam bit BP_BUILT = 1'b0;
`endif

    localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    localparam logic [7:0] RES4 [4] = '{8'h00, 8'h08, 8'h01, 8'h0e};
    localparam logic [7:0] RES3 [3] = '{8'h11, 8'h22, 8'h33};

    logic       clock = 1'b0;
    logic       reset, run_sw, step_btn, endseq, bp_en;
    logic [7:0] pc_in, bp_adrs, resdt, resad, resad3;
    logic [1:0] ressel, mode;
    logic       cpu_ce, bp_hit;
    logic [7:0] seg;
    logic [1:0] dig_en;
    logic       unused_ce3, unused_hit3;
    logic [1:0] unused_mode3, unused_dig3;
    logic [7:0] unused_seg3;

    int checks = 0;
    int errors = 0;

    // behavioural model state: 0 halt, 1 step, 2 run, 3 done
    int         m, t;
    bit         step_prev, armed, hit;
    logic [7:0] rd_q, rd_seg;
    logic [1:0] last_sel;
    logic [7:0] pc_cnt, pc_mask;
    int         ce_seen;

    always #5 clock = ~clock;

    cpu_debug_ctrl #(.AW(8), .DW(8), .DIGITS(ND), .NUM_RES(4), .SEL_W(2),
                     .RES_MAP({8'h0e, 8'h01, 8'h08, 8'h00}), .SCAN_DIV(SD)) dut (
        .clock(clock), .reset(reset), .run_sw(run_sw), .step_btn(step_btn), .endseq(endseq),
        .pc_in(pc_in), .bp_adrs(bp_adrs), .bp_en(bp_en), .ressel(ressel), .resad(resad),
        .resdt(resdt), .cpu_ce(cpu_ce), .bp_hit(bp_hit), .mode(mode), .seg(seg), .dig_en(dig_en)
    );

    cpu_debug_ctrl #(.AW(8), .DW(8), .DIGITS(ND), .NUM_RES(3), .SEL_W(2),
                     .RES_MAP(24'h33_22_11), .SCAN_DIV(SD)) dut3 (
        .clock(clock), .reset(reset), .run_sw(run_sw), .step_btn(step_btn), .endseq(endseq),
        .pc_in(pc_in), .bp_adrs(bp_adrs), .bp_en(bp_en), .ressel(ressel), .resad(resad3),
        .resdt(resdt), .cpu_ce(unused_ce3), .bp_hit(unused_hit3), .mode(unused_mode3),
        .seg(unused_seg3), .dig_en(unused_dig3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m = 0; step_prev = 0; armed = 0; hit = 0;
        t = 0; rd_q = '0; rd_seg = '0; last_sel = '0;
    endtask

    // One clock: check all outputs at the falling edge, then advance the model
    task automatic cycle();
        bit         match, ce_exp;
        int         idx;
        logic [7:0] exp_seg, exp_rad3;
        logic [1:0] exp_dig;
        @(negedge clock);
        match  = BP_BUILT && bp_en && (pc_in == bp_adrs) && armed;
        ce_exp = !reset && (m == 1 || (m == 2 && !match));
        if (t == 0) begin
            exp_dig = 2'b01;
            exp_seg = SEG_TAB[0];
        end else begin
            idx     = ((t - 1) / SD) % ND;
            exp_dig = 2'(1 << idx);
            exp_seg = SEG_TAB[4'(rd_seg >> (4 * idx))];
        end
        exp_rad3 = (last_sel < 3) ? RES3[last_sel] : RES3[0];
        check_eq("cpu_ce", cpu_ce, ce_exp);
        check_eq("mode", mode, m);
        check_eq("bp_hit", bp_hit, hit);
        check_eq("resad", resad, RES4[last_sel]);
        check_eq("resad_nres3", resad3, exp_rad3);
        check_eq("dig_en", dig_en, exp_dig);
        check_eq("seg", seg, exp_seg);
        if (cpu_ce) ce_seen++;
        if (reset) begin
            model_reset();
        end else begin
            case (m)
                0: if (run_sw) begin m = 2; armed = 0; hit = 0; end
                   else if (step_btn && !step_prev) begin m = 1; hit = 0; end
                1: m = 0;
                2: begin
                    if (endseq) m = 3;
                    else if (match) begin m = 0; hit = 1; end
                    else if (!run_sw) m = 0;
                    armed = 1;
                end
                default: m = 3;
            endcase
            step_prev = step_btn;
            t++;
            rd_seg   = rd_q;
            rd_q     = resdt;
            last_sel = ressel;
        end
        if (ce_exp) pc_cnt = pc_cnt + 1'b1;
        @(posedge clock);
        #1;
        pc_in = pc_cnt & pc_mask;
    endtask

    initial begin
        reset = 1'b1; run_sw = 0; step_btn = 0; endseq = 0; bp_en = 0;
        bp_adrs = 8'hF0; resdt = 8'h00; ressel = 2'd0;
        pc_cnt = 0; pc_mask = 8'hFF; pc_in = 0; ce_seen = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check_eq("idle_mode", mode, 2'b00);
        check_eq("idle_dig_en", dig_en, 2'b01);
        check_eq("idle_resad", resad, 8'h00);

        // single step: hold the button for five cycles
        ce_seen = 0;
        step_btn = 1'b1;
        repeat (5) cycle();
        step_btn = 1'b0;
        repeat (3) cycle();
        check_eq("step_pulses", ce_seen, 1);
        check_eq("step_mode", mode, 2'b00);

        // breakpoint at 0x05 while running from pc 0
        pc_cnt = 0; pc_in = 0; bp_adrs = 8'h05; bp_en = 1'b1; run_sw = 1'b1;
        repeat (7) cycle();
        run_sw = 1'b0;
        repeat (2) cycle();
        check_eq("bp_stop_mode", mode, 2'b00);
        check_eq("bp_stop_hit", bp_hit, 32'(BP_BUILT));
        ce_seen = 0;
        run_sw = 1'b1;
        repeat (5) cycle();
        check_eq("bp_resume_ce", ce_seen, 4);
        run_sw = 1'b0;
        repeat (2) cycle();

        // endseq together with a breakpoint match
        reset = 1'b1; cycle(); reset = 1'b0;
        bp_adrs = 8'hF0; run_sw = 1'b1;
        repeat (4) cycle();
        bp_adrs = pc_in; endseq = 1'b1;
        cycle();
        endseq = 1'b0;
        cycle();
        check_eq("done_mode", mode, 2'b11);
        check_eq("done_hit", bp_hit, 0);
        for (int i = 0; i < 4; i++) begin
            run_sw = ~run_sw;
            cycle();
        end
        check_eq("done_sticky", mode, 2'b11);
        reset = 1'b1; cycle(); reset = 1'b0; run_sw = 1'b0;

        // resource selector sweep including the out-of-range entry on the 3-entry instance
        for (int s = 0; s < 4; s++) begin
            ressel = 2'(s);
            repeat (2) cycle();
        end
        check_eq("resad_sel3", resad, 8'h0e);
        check_eq("resad3_sel3", resad3, 8'h11);

        // scanned display of a fixed value
        resdt = 8'hA5;
        repeat (20) cycle();

        // randomized operation
        pc_mask = 8'h0F;
        for (int n = 0; n < 4000; n++) begin
            reset    = (m == 3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
            step_btn = ($urandom_range(0, 2) == 0);
            endseq   = ($urandom_range(0, 99) == 0);
            bp_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bp_adrs = 8'($urandom_range(0, 15));
            ressel   = 2'($urandom);
            if ($urandom_range(0, 3) == 0) resdt = 8'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
